// File: rtl/half_adder_unit.sv
// Purpose: single-bit half adder with combinational and registered results, a valid flag and a saturating carry counter.
// Latency: sum/carry are combinational (0 cycles); sum_q/carry_q/valid_q/carry_cnt update one cycle after a/b are sampled.
// Backpressure: none; a/b are sampled unconditionally on every rising edge.
module half_adder_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             a,
  input  logic             b,
  output logic             sum,
  output logic             carry,
  output logic             sum_q,
  output logic             carry_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] carry_cnt
);

  // Counter ceiling; the counter parks here instead of wrapping.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Combinational result path: {carry, sum} is the 2-bit sum of a and b, reset has no effect here.
  assign sum   = a ^ b;
  assign carry = a & b;

  // Registered result path; rstn is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rstn) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= a ^ b;
      carry_q <= a & b;
      valid_q <= 1'b1;
    end
  end

  // Saturating count of carry events; reset wins over a coincident carry.
  always_ff @(posedge clk) begin
    if (rstn) begin
      carry_cnt <= '0;
    end else if ((a & b) && (carry_cnt != CNT_MAX)) begin
      carry_cnt <= carry_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_half_adder_unit.sv
// Bench for half_adder_unit: a default-width instance and a 2-bit counter instance share the same inputs.
// Expected values come from an arithmetic model: registered pair = a + b of the previous edge, counter = min(carries since reset, 2^W-1).
module tb_half_adder_unit;

  logic clk = 1'b0;
  logic rstn, a, b;

  logic       sum, carry, sum_q, carry_q, valid_q;
  logic [7:0] carry_cnt;
  logic       s_sum, s_carry, s_sum_q, s_carry_q, s_valid_q;
  logic [1:0] s_carry_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         n_carry = 0;
  bit         m_valid = 1'b0;
  logic [1:0] m_pair  = 2'b00;

  always #5 clk = ~clk;

  half_adder_unit #(.CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .a(a), .b(b),
    .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q),
    .valid_q(valid_q), .carry_cnt(carry_cnt)
  );

  half_adder_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rstn(rstn), .a(a), .b(b),
    .sum(s_sum), .carry(s_carry), .sum_q(s_sum_q), .carry_q(s_carry_q),
    .valid_q(s_valid_q), .carry_cnt(s_carry_cnt)
  );

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Advance one rising edge and update the model from the inputs seen at that edge.
  task automatic step();
    bit ra, rb, rr;
    ra = a; rb = b; rr = rstn;
    @(posedge clk);
    #1;
    if (rr) begin
      n_carry = 0;
      m_valid = 1'b0;
      m_pair  = 2'b00;
    end else begin
      m_pair  = {1'b0, ra} + {1'b0, rb};
      m_valid = 1'b1;
      n_carry = n_carry + int'(ra & rb);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1; a = 1'b0; b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (sum !== 1'b1 || carry !== 1'b0) begin
        errors++;
        $display("FAIL reset_comb cycle %0d: sum=%b carry=%b, want sum=1 carry=0", i, sum, carry);
      end
      step();
      checks++;
      if (sum_q !== 1'b0 || carry_q !== 1'b0 || valid_q !== 1'b0 || carry_cnt !== 8'd0) begin
        errors++;
        $display("FAIL reset_regs cycle %0d: sum_q=%b carry_q=%b valid_q=%b cnt=%0d, want all 0",
                 i, sum_q, carry_q, valid_q, carry_cnt);
      end
      checks++;
      if (s_sum_q !== 1'b0 || s_carry_q !== 1'b0 || s_valid_q !== 1'b0 || s_carry_cnt !== 2'd0) begin
        errors++;
        $display("FAIL reset_regs_w2 cycle %0d: sum_q=%b carry_q=%b valid_q=%b cnt=%0d, want all 0",
                 i, s_sum_q, s_carry_q, s_valid_q, s_carry_cnt);
      end
    end
  endtask

  task automatic test_truth_table();
    logic [3:0] exp_s, exp_c;
    exp_s = 4'b0110; // index = {a,b}
    exp_c = 4'b1000;
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {a, b} = 2'(i);
      #1;
      checks++;
      if (sum !== exp_s[i] || carry !== exp_c[i]) begin
        errors++;
        $display("FAIL tt_comb ab=%0d: sum=%b carry=%b, want %b %b", i, sum, carry, exp_s[i], exp_c[i]);
      end
      step();
      checks++;
      if (sum_q !== exp_s[i] || carry_q !== exp_c[i] || valid_q !== 1'b1) begin
        errors++;
        $display("FAIL tt_regs ab=%0d: sum_q=%b carry_q=%b valid_q=%b, want %b %b 1",
                 i, sum_q, carry_q, valid_q, exp_s[i], exp_c[i]);
      end
    end
    checks++;
    if (carry_cnt !== 8'd1) begin
      errors++;
      $display("FAIL tt_count: carry_cnt=%0d, want 1", carry_cnt);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt[5] = '{1, 2, 3, 3, 3};
    rstn = 1'b1; a = 1'b1; b = 1'b1;
    step();
    rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (s_carry_cnt !== 2'(exp_cnt[i])) begin
        errors++;
        $display("FAIL sat_w2 cycle %0d: carry_cnt=%0d, want %0d", i, s_carry_cnt, exp_cnt[i]);
      end
      checks++;
      if (carry_cnt !== 8'(i + 1)) begin
        errors++;
        $display("FAIL sat_w8 cycle %0d: carry_cnt=%0d, want %0d", i, carry_cnt, i + 1);
      end
    end
  endtask

  // Runs straight after saturation: narrow counter at 3, sum_q=0, carry_q=1.
  task automatic test_mid_reset();
    checks++;
    if (s_carry_cnt !== 2'd3 || s_sum_q !== 1'b0 || s_carry_q !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: cnt=%0d sum_q=%b carry_q=%b, want 3 0 1", s_carry_cnt, s_sum_q, s_carry_q);
    end
    rstn = 1'b1; a = 1'b1; b = 1'b1;
    #1;
    checks++;
    if (s_sum !== 1'b0 || s_carry !== 1'b1) begin
      errors++;
      $display("FAIL midrst_comb: sum=%b carry=%b, want 0 1", s_sum, s_carry);
    end
    step();
    checks++;
    if (s_sum_q !== 1'b0 || s_carry_q !== 1'b0 || s_valid_q !== 1'b0 || s_carry_cnt !== 2'd0 ||
        carry_cnt !== 8'd0 || valid_q !== 1'b0) begin
      errors++;
      $display("FAIL midrst_regs: sum_q=%b carry_q=%b valid_q=%b cnt=%0d cnt8=%0d, want all 0",
               s_sum_q, s_carry_q, s_valid_q, s_carry_cnt, carry_cnt);
    end
    rstn = 1'b0;
    step();
    checks++;
    if (s_carry_q !== 1'b1 || s_carry_cnt !== 2'd1 || s_valid_q !== 1'b1 || carry_cnt !== 8'd1) begin
      errors++;
      $display("FAIL midrst_after: carry_q=%b cnt=%0d valid_q=%b cnt8=%0d, want 1 1 1 1",
               s_carry_q, s_carry_cnt, s_valid_q, carry_cnt);
    end
  endtask

  task automatic test_random();
    int prev8, prev2;
    bit was_rst;
    prev8 = carry_cnt;
    prev2 = s_carry_cnt;
    for (int i = 0; i < 1000; i++) begin
      a    = 1'($urandom);
      b    = 1'($urandom);
      rstn = ($urandom_range(0, 49) == 0);
      was_rst = rstn;
      #1;
      checks++;
      if ({carry, sum} !== ({1'b0, a} + {1'b0, b}) || {s_carry, s_sum} !== ({1'b0, a} + {1'b0, b})) begin
        errors++;
        $display("FAIL rnd_comb %0d: a=%b b=%b {carry,sum}=%b%b", i, a, b, carry, sum);
      end
      step();
      checks++;
      if ({carry_q, sum_q} !== m_pair || valid_q !== m_valid ||
          {s_carry_q, s_sum_q} !== m_pair || s_valid_q !== m_valid) begin
        errors++;
        $display("FAIL rnd_regs %0d: carry_q,sum_q=%b%b valid_q=%b, want %b valid %b",
                 i, carry_q, sum_q, valid_q, m_pair, m_valid);
      end
      checks++;
      if ((sum_q & carry_q) !== 1'b0 || (s_sum_q & s_carry_q) !== 1'b0) begin
        errors++;
        $display("FAIL rnd_excl %0d: sum_q=%b carry_q=%b both set", i, sum_q, carry_q);
      end
      checks++;
      if (carry_cnt !== 8'(sat(n_carry, 8)) || s_carry_cnt !== 2'(sat(n_carry, 2))) begin
        errors++;
        $display("FAIL rnd_cnt %0d: cnt8=%0d cnt2=%0d, want %0d %0d",
                 i, carry_cnt, s_carry_cnt, sat(n_carry, 8), sat(n_carry, 2));
      end
      if (!was_rst) begin
        checks++;
        if (int'(carry_cnt) < prev8 || int'(s_carry_cnt) < prev2) begin
          errors++;
          $display("FAIL rnd_mono %0d: cnt8 %0d->%0d cnt2 %0d->%0d", i, prev8, carry_cnt, prev2, s_carry_cnt);
        end
      end
      prev8 = carry_cnt;
      prev2 = s_carry_cnt;
    end
  endtask

  initial begin
    rstn = 1'b1; a = 1'b0; b = 1'b0;
    test_reset();
    test_truth_table();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_adder_unit.md
# half_adder_unit

Single-bit half adder with combinational and registered result paths, an output-valid flag and a saturating carry-event counter. It sits in the low-level verification block set as the smallest arithmetic leaf, and is the formal-property target for sum/carry correctness. All state is clocked by one clock and cleared by a synchronous, active-high reset.

## Interface

Parameters:
- CNT_W, default 8: width of the carry-event counter. Legal range is 1–32.

Ports (name, direction, width, meaning):
- clk, input, 1: single clock. All state updates on the rising edge.
- rstn, input, 1: reset. Synchronous and active-high: 1 = reset asserted. The port keeps the codebase's name despite its polarity.
- a, input, 1: addend A.
- b, input, 1: addend B.
- sum, output, 1: combinational a XOR b.
- carry, output, 1: combinational a AND b.
- sum_q, output, 1: registered sum.
- carry_q, output, 1: registered carry.
- valid_q, output, 1: registered outputs hold a result sampled outside reset.
- carry_cnt, output, CNT_W: saturating count of rising edges at which carry was 1 and reset was low.

## Operation

- Combinational path, with no state:
  - sum = a ^ b.
  - carry = a & b.
  - Invariant: {carry, sum} == a + b, treated as a 2-bit unsigned value, at all times including during reset.
- Registered path, at each rising edge of clk:
  - If rstn == 1: sum_q, carry_q and valid_q are set to 0, and carry_cnt is set to 0.
  - Otherwise:
    - sum_q ← a ^ b.
    - carry_q ← a & b.
    - valid_q ← 1.
    - If (a & b) and carry_cnt != all-ones, carry_cnt increments by 1. Otherwise carry_cnt holds.
- Counter saturation: at 2^CNT_W − 1 the counter holds its value and never wraps.
- Invariants:
  - sum_q and carry_q are never both 1.
  - When valid_q == 0, sum_q == 0 and carry_q == 0.
- Power-up state is undefined until the first edge with rstn == 1. Verification applies properties only after one reset edge.

## Timing

- Combinational outputs: zero latency, and they follow a/b within the same cycle.
- Registered outputs: one-cycle latency. The values of a/b at edge N appear on sum_q/carry_q after edge N.
- Reset values after any edge with rstn == 1: sum_q = 0, carry_q = 0, valid_q = 0, carry_cnt = 0.
- Reset asserted mid-operation: it takes effect at the next edge. Registered results and counter progress are discarded, and the combinational outputs are unaffected.
- First edge with rstn == 0: valid_q becomes 1 and the first real result is captured on the same edge.
- Simultaneous carry and saturation: the counter holds.
- Simultaneous carry and reset: reset wins and the counter becomes 0.
- There is no handshake. Inputs are sampled unconditionally every cycle.

## Test plan

- Reset hold: apply rstn = 1 with a = 0, b = 1 for 2 cycles.
  - Required: sum = 1 and carry = 0 combinationally throughout.
  - Required: sum_q = 0, carry_q = 0, valid_q = 0 and carry_cnt = 0 after each edge.
- Exhaustive truth table: release reset, then drive (a,b) = 00, 01, 10, 11 on consecutive cycles.
  - Required: sum_q/carry_q equal 0/0, 1/0, 1/0, 0/1 one cycle later.
  - Required: valid_q = 1 from the first post-reset edge.
  - Required: carry_cnt = 1 at the end.
- Saturation: with CNT_W = 2, hold a = b = 1 for 5 cycles out of reset.
  - Required: carry_cnt reads 1, 2, 3, 3, 3.
- Mid-run reset: with carry_cnt = 3, sum_q = 0 and carry_q = 1, assert rstn = 1 for one edge while a = b = 1.
  - Required: all registered outputs and carry_cnt are 0 after that edge.
  - Required: the next edge with rstn = 0 gives carry_q = 1 and carry_cnt = 1.
- Random/formal check over 1000 cycles:
  - {carry, sum} == a + b at all times.
  - sum_q & carry_q == 0 at all times.
  - carry_cnt is monotonic between resets.
